axi4_lite_reg_slave: RTL and testbench
======================================

Name: axi4_lite_reg_slave

Overview:
- AXI4-Lite slave register bank: the block that sits on the far side of an AXI4-Lite master port and consumes what that master produces.
- Provides NREGS read/write control registers to fabric logic, with a per-register write pulse.
- Responds OKAY to in-range addresses and SLVERR to out-of-range ones.
- Any stimulus driver or idle plug can sit directly upstream of it.

Parameters:
- DW, 32, AXI data width and register width (32 or 64).
- AW, 32, AXI address width.
- NREGS, 16, number of registers (power of 2, 2..256).

Ports:
- clk  in  1  single clock for everything
- resetn  in  1  asynchronous, active-low reset
- S_AXI_AWADDR  in  AW  write address
- S_AXI_AWVALID  in  1  write address valid
- S_AXI_AWREADY  out  1  write address ready
- S_AXI_WDATA  in  DW  write data
- S_AXI_WSTRB  in  DW/8  byte strobes
- S_AXI_WVALID  in  1  write data valid
- S_AXI_WREADY  out  1  write data ready
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID  out  1  write response valid
- S_AXI_BREADY  in  1  write response ready
- S_AXI_ARADDR  in  AW  read address
- S_AXI_ARVALID  in  1  read address valid
- S_AXI_ARREADY  out  1  read address ready
- S_AXI_RDATA  out  DW  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  read data ready
- reg_out  out  NREGS*DW  flattened registers; reg i at [i*DW +: DW]
- wr_pulse  out  NREGS  one-cycle pulse, bit i when reg i written

Behaviour:
- Reset (resetn low, async): all READY/VALID outputs 0, BRESP/RRESP 0, RDATA 0, all registers 0, wr_pulse 0.
- First clk edge after resetn rises: AWREADY, WREADY, ARREADY go to 1.
- Address decode:
  - byte address; index = addr >> log2(DW/8); low byte-offset bits ignored.
  - In range iff addr < NREGS*DW/8.
  - Out of range: no register change, response 2'b10 (SLVERR), RDATA 0.
  - In range: response 2'b00.
- Write FSM, states W_IDLE and W_RESP:
  - W_IDLE: AWREADY=1 until an AW handshake is captured, then 0. WREADY=1 until a W handshake is captured, then 0.
  - AW and W may arrive in either order or on the same edge.
  - On the edge after both are captured: register updated, wr_pulse[idx]=1 for exactly that one cycle, BVALID=1 with BRESP, state goes to W_RESP.
  - W_RESP: BVALID held with BRESP stable until BREADY is sampled high. On that edge BVALID drops and state returns to W_IDLE. AWREADY and WREADY are 1 from that edge.
  - Back-to-back throughput: one write per 3 cycles minimum.
- Read FSM, states R_IDLE and R_DATA:
  - R_IDLE: ARREADY=1.
  - On the ARVALID&ARREADY edge: RDATA captured from the register values before that edge's update, RRESP set, RVALID=1, ARREADY=0, state goes to R_DATA.
  - R_DATA: RDATA, RRESP and RVALID held until RREADY is sampled high. Then RVALID drops and ARREADY=1 on that edge.
- Read and write channels are fully independent.
  - Read handshake on the same edge as the register update of a write to the same register: read returns the old value.
- reg_out is a direct register output (no extra latency): the new value is visible the cycle wr_pulse is high.
- Reset asserted mid-transaction: the transaction is abandoned, all outputs return to reset values immediately, and no partial register write occurs.

Optional Feature:
- Macro: AXI_REG_SLAVE_WSTRB_EN
- Defined: only bytes with S_AXI_WSTRB[b]=1 are written; WSTRB=0 still produces the OKAY response and the wr_pulse.
- Undefined: WSTRB ignored; the full DW word is written on every in-range write.

Test Plan:
- Reset, then read reg 3 (ARADDR=0x0C) -> RVALID one cycle after handshake, RDATA=0, RRESP=0; ARREADY=1 again after RREADY.
- AW=0x08 two cycles before W=0xDEADBEEF, BREADY=1 -> reg 2 = 0xDEADBEEF, wr_pulse=0x0004 for exactly one cycle, BRESP=0; readback matches.
- AW and W same cycle to 0x40 (NREGS=16, DW=32) -> BRESP=2'b10, no wr_pulse, reg_out unchanged; read of 0x40 -> RRESP=2'b10, RDATA=0.
- Hold BREADY=0 for 5 cycles after a write -> BVALID and BRESP stable, AWREADY=WREADY=0 throughout; release -> BVALID drops, readies return.
- With AXI_REG_SLAVE_WSTRB_EN defined: reg 1 = 0x11223344, write 0xAABBCCDD with WSTRB=4'b0101 -> reg 1 = 0x11BB33DD. Without the macro -> reg 1 = 0xAABBCCDD.
- Assert resetn low while BVALID=1 and RVALID=1 -> all valids 0 and registers 0 asynchronously; readies 1 on first edge after release.

Source files
------------

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite slave exposing NREGS read/write registers with per-register write pulses.
// Define AXI_REG_SLAVE_WSTRB_EN to honour WSTRB byte lanes; otherwise whole words are written.
module axi4_lite_reg_slave #(
   parameter int DW    = 32,
   parameter int AW    = 32,
   parameter int NREGS = 16
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic [AW-1:0]       S_AXI_AWADDR,
   input  logic                S_AXI_AWVALID,
   output logic                S_AXI_AWREADY,
   input  logic [DW-1:0]       S_AXI_WDATA,
   input  logic [DW/8-1:0]     S_AXI_WSTRB,
   input  logic                S_AXI_WVALID,
   output logic                S_AXI_WREADY,
   output logic [1:0]          S_AXI_BRESP,
   output logic                S_AXI_BVALID,
   input  logic                S_AXI_BREADY,
   input  logic [AW-1:0]       S_AXI_ARADDR,
   input  logic                S_AXI_ARVALID,
   output logic                S_AXI_ARREADY,
   output logic [DW-1:0]       S_AXI_RDATA,
   output logic [1:0]          S_AXI_RRESP,
   output logic                S_AXI_RVALID,
   input  logic                S_AXI_RREADY,
   output logic [NREGS*DW-1:0] reg_out,
   output logic [NREGS-1:0]    wr_pulse
);

   localparam int ADDR_LSB = $clog2(DW/8);
   localparam int IDX_W    = $clog2(NREGS);
   localparam int TOP_LSB  = ADDR_LSB + IDX_W;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t          w_state;
   r_state_t          r_state;
   logic [DW-1:0]     regs [NREGS];
   logic              aw_done;
   logic              w_done;
   logic              aw_ok;
   logic [IDX_W-1:0]  aw_idx;
   logic [DW-1:0]     w_data_q;
   logic [DW/8-1:0]   w_strb_q;
   logic [IDX_W-1:0]  aw_idx_in;
   logic [IDX_W-1:0]  ar_idx_in;
   logic              aw_ok_in;
   logic              ar_ok_in;
   logic              unused_bits;

   // Anything at or above NREGS*DW/8 has a nonzero bit above the index field.
   assign aw_idx_in = S_AXI_AWADDR[TOP_LSB-1:ADDR_LSB];
   assign ar_idx_in = S_AXI_ARADDR[TOP_LSB-1:ADDR_LSB];
   assign aw_ok_in  = (S_AXI_AWADDR[AW-1:TOP_LSB] == '0);
   assign ar_ok_in  = (S_AXI_ARADDR[AW-1:TOP_LSB] == '0);

`ifdef AXI_REG_SLAVE_WSTRB_EN
   assign unused_bits = &{1'b0, S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};
`else
   assign unused_bits = &{1'b0, S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0],
                          S_AXI_WSTRB, w_strb_q};
`endif

   // Write channel: AW and W are latched independently, then committed one edge later.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         w_state       <= W_IDLE;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
         aw_ok         <= 1'b0;
         aw_idx        <= '0;
         w_data_q      <= '0;
         w_strb_q      <= '0;
         S_AXI_AWREADY <= 1'b0;
         S_AXI_WREADY  <= 1'b0;
         S_AXI_BVALID  <= 1'b0;
         S_AXI_BRESP   <= 2'b00;
         wr_pulse      <= '0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         wr_pulse <= '0;
         case (w_state)
            W_IDLE: begin
               if (S_AXI_AWREADY && S_AXI_AWVALID) begin
                  aw_done       <= 1'b1;
                  aw_idx        <= aw_idx_in;
                  aw_ok         <= aw_ok_in;
                  S_AXI_AWREADY <= 1'b0;
               end else if (!aw_done) begin
                  S_AXI_AWREADY <= 1'b1;
               end
               if (S_AXI_WREADY && S_AXI_WVALID) begin
                  w_done       <= 1'b1;
                  w_data_q     <= S_AXI_WDATA;
                  w_strb_q     <= S_AXI_WSTRB;
                  S_AXI_WREADY <= 1'b0;
               end else if (!w_done) begin
                  S_AXI_WREADY <= 1'b1;
               end
               if (aw_done && w_done) begin
                  if (aw_ok) begin
`ifdef AXI_REG_SLAVE_WSTRB_EN
                     for (int b = 0; b < DW/8; b++)
                        if (w_strb_q[b]) regs[aw_idx][b*8 +: 8] <= w_data_q[b*8 +: 8];
`else
                     regs[aw_idx] <= w_data_q;
`endif
                     wr_pulse[aw_idx] <= 1'b1;
                  end
                  aw_done      <= 1'b0;
                  w_done       <= 1'b0;
                  S_AXI_BVALID <= 1'b1;
                  S_AXI_BRESP  <= aw_ok ? 2'b00 : 2'b10;
                  w_state      <= W_RESP;
               end
            end
            W_RESP: begin
               if (S_AXI_BREADY) begin
                  S_AXI_BVALID  <= 1'b0;
                  S_AXI_AWREADY <= 1'b1;
                  S_AXI_WREADY  <= 1'b1;
                  w_state       <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Read channel samples the pre-edge register contents, so a colliding write reads old data.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state       <= R_IDLE;
         S_AXI_ARREADY <= 1'b0;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RDATA   <= '0;
         S_AXI_RRESP   <= 2'b00;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (S_AXI_ARREADY && S_AXI_ARVALID) begin
                  S_AXI_RDATA   <= ar_ok_in ? regs[ar_idx_in] : '0;
                  S_AXI_RRESP   <= ar_ok_in ? 2'b00 : 2'b10;
                  S_AXI_RVALID  <= 1'b1;
                  S_AXI_ARREADY <= 1'b0;
                  r_state       <= R_DATA;
               end else begin
                  S_AXI_ARREADY <= 1'b1;
               end
            end
            R_DATA: begin
               if (S_AXI_RREADY) begin
                  S_AXI_RVALID  <= 1'b0;
                  S_AXI_ARREADY <= 1'b1;
                  r_state       <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < NREGS; i++) begin : g_reg_out
      assign reg_out[i*DW +: DW] = regs[i];
   end

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed self-checking bench for axi4_lite_reg_slave at DW=32, AW=32, NREGS=16.
module tb_axi4_lite_reg_slave;

   logic          clk;
   logic          resetn;
   logic [31:0]   awaddr, wdata, araddr;
   logic [3:0]    wstrb;
   logic          awvalid, wvalid, bready, arvalid, rready;
   logic          awready, wready, bvalid, arready, rvalid;
   logic [1:0]    bresp, rresp;
   logic [31:0]   rdata;
   logic [511:0]  reg_out;
   logic [15:0]   wr_pulse;
   logic [31:0]   exp_regs [16];
   int            checks;
   int            passed;

   axi4_lite_reg_slave #(.DW(32), .AW(32), .NREGS(16)) dut (
      .clk(clk), .resetn(resetn),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .reg_out(reg_out), .wr_pulse(wr_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outputs are sampled 1ns after the rising edge they were launched on.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) passed++;
      else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
   endtask

   task automatic applyStimulus(input logic [31:0] aw_a, input logic aw_v, input logic [31:0] w_d,
                                input logic [3:0] w_s, input logic w_v, input logic b_r,
                                input logic [31:0] ar_a, input logic ar_v, input logic r_r);
      awaddr = aw_a; awvalid = aw_v; wdata = w_d; wstrb = w_s; wvalid = w_v;
      bready = b_r; araddr = ar_a; arvalid = ar_v; rready = r_r;
   endtask

   function automatic logic [31:0] reg_at(input int i);
      return reg_out[i*32 +: 32];
   endfunction

   task automatic checkAllRegs(input string tag);
      for (int i = 0; i < 16; i++) checkOutput($sformatf("%s_reg%0d", tag, i), 64'(reg_at(i)), 64'(exp_regs[i]));
   endtask

   // AW and W together with BREADY high; waits a bounded time for BVALID.
   task automatic writeReg(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] exp_resp, input logic [15:0] exp_pulse, input string tag);
      bit got;
      got = 0;
      applyStimulus(addr, 1'b1, data, strb, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
      tick();
      applyStimulus(addr, 1'b0, data, strb, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
      for (int n = 0; n < 8; n++) begin
         if (bvalid) begin got = 1; break; end
         tick();
      end
      if (!got) checkOutput({tag, "_bvalid_timeout"}, 64'(bvalid), 64'(1));
      checkOutput({tag, "_bresp"}, 64'(bresp), 64'(exp_resp));
      checkOutput({tag, "_wr_pulse"}, 64'(wr_pulse), 64'(exp_pulse));
      tick();
      checkOutput({tag, "_bvalid_drop"}, 64'(bvalid), 64'(0));
   endtask

   task automatic readReg(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input string tag);
      applyStimulus(32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, addr, 1'b1, 1'b0);
      tick();
      applyStimulus(32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, addr, 1'b0, 1'b0);
      checkOutput({tag, "_rvalid"}, 64'(rvalid), 64'(1));
      checkOutput({tag, "_rdata"}, 64'(rdata), 64'(exp_data));
      checkOutput({tag, "_rresp"}, 64'(rresp), 64'(exp_resp));
      checkOutput({tag, "_arready_busy"}, 64'(arready), 64'(0));
      rready = 1'b1;
      tick();
      rready = 1'b0;
      checkOutput({tag, "_rvalid_drop"}, 64'(rvalid), 64'(0));
      checkOutput({tag, "_arready_back"}, 64'(arready), 64'(1));
   endtask

   initial begin
      checks = 0;
      passed = 0;
      for (int i = 0; i < 16; i++) exp_regs[i] = 32'h0;
      resetn = 1'b0;
      applyStimulus(32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      tick();
      $display("[TB] reset state");
      checkOutput("rst_awready", 64'(awready), 64'(0));
      checkOutput("rst_arready", 64'(arready), 64'(0));
      checkOutput("rst_bvalid", 64'(bvalid), 64'(0));
      checkOutput("rst_rvalid", 64'(rvalid), 64'(0));
      checkOutput("rst_reg_out", 64'(|reg_out), 64'(0));
      resetn = 1'b1;
      tick();
      checkOutput("post_rst_awready", 64'(awready), 64'(1));
      checkOutput("post_rst_wready", 64'(wready), 64'(1));
      checkOutput("post_rst_arready", 64'(arready), 64'(1));

      $display("[TB] read reg 3 after reset");
      readReg(32'h0C, 32'h0, 2'b00, "rd_reg3");

      $display("[TB] AW two cycles ahead of W");
      applyStimulus(32'h08, 1'b1, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
      tick();
      checkOutput("split_awready_low", 64'(awready), 64'(0));
      applyStimulus(32'h08, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
      tick();
      checkOutput("split_no_bvalid", 64'(bvalid), 64'(0));
      applyStimulus(32'h08, 1'b0, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
      tick();
      checkOutput("split_wready_low", 64'(wready), 64'(0));
      checkOutput("split_no_pulse_yet", 64'(wr_pulse), 64'(0));
      applyStimulus(32'h08, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
      tick();
      exp_regs[2] = 32'hDEADBEEF;
      checkOutput("split_wr_pulse", 64'(wr_pulse), 64'h0004);
      checkOutput("split_reg2", 64'(reg_at(2)), 64'hDEADBEEF);
      checkOutput("split_bvalid", 64'(bvalid), 64'(1));
      checkOutput("split_bresp", 64'(bresp), 64'(0));
      tick();
      checkOutput("split_pulse_gone", 64'(wr_pulse), 64'(0));
      checkOutput("split_bvalid_drop", 64'(bvalid), 64'(0));
      checkOutput("split_awready_back", 64'(awready), 64'(1));
      checkOutput("split_wready_back", 64'(wready), 64'(1));
      readReg(32'h08, 32'hDEADBEEF, 2'b00, "rd_reg2");

      $display("[TB] out-of-range access");
      writeReg(32'h40, 32'h55AA55AA, 4'hF, 2'b10, 16'h0000, "oor_wr");
      checkAllRegs("oor_unchanged");
      readReg(32'h40, 32'h0, 2'b10, "oor_rd");

      $display("[TB] BREADY held low");
      applyStimulus(32'h14, 1'b1, 32'h12345678, 4'hF, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      applyStimulus(32'h14, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      exp_regs[5] = 32'h12345678;
      for (int n = 0; n < 5; n++) begin
         checkOutput($sformatf("stall_bvalid_%0d", n), 64'(bvalid), 64'(1));
         checkOutput($sformatf("stall_bresp_%0d", n), 64'(bresp), 64'(0));
         checkOutput($sformatf("stall_readies_%0d", n), 64'({awready, wready}), 64'(0));
         tick();
      end
      bready = 1'b1;
      tick();
      checkOutput("stall_bvalid_drop", 64'(bvalid), 64'(0));
      checkOutput("stall_readies_back", 64'({awready, wready}), 64'(3));
      checkOutput("stall_reg5", 64'(reg_at(5)), 64'h12345678);

      $display("[TB] read collides with write to same register");
      applyStimulus(32'h14, 1'b1, 32'hCAFEF00D, 4'hF, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
      tick();
      applyStimulus(32'h14, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1, 32'h14, 1'b1, 1'b0);
      tick();
      exp_regs[5] = 32'hCAFEF00D;
      checkOutput("coll_rdata_old", 64'(rdata), 64'h12345678);
      checkOutput("coll_rvalid", 64'(rvalid), 64'(1));
      checkOutput("coll_reg5_new", 64'(reg_at(5)), 64'hCAFEF00D);
      checkOutput("coll_wr_pulse", 64'(wr_pulse), 64'h0020);
      applyStimulus(32'h0, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
      tick();
      rready = 1'b0;
      checkOutput("coll_rvalid_drop", 64'(rvalid), 64'(0));

      $display("[TB] byte strobes");
      writeReg(32'h04, 32'h11223344, 4'hF, 2'b00, 16'h0002, "strb_init");
      writeReg(32'h04, 32'hAABBCCDD, 4'b0101, 2'b00, 16'h0002, "strb_part");
`ifdef AXI_REG_SLAVE_WSTRB_EN
      exp_regs[1] = 32'h11BB33DD;
`else
      exp_regs[1] = 32'hAABBCCDD;
`endif
      checkAllRegs("strb_regs");

      $display("[TB] reset during outstanding responses");
      applyStimulus(32'h18, 1'b1, 32'h0BADF00D, 4'hF, 1'b1, 1'b0, 32'h08, 1'b1, 1'b0);
      tick();
      applyStimulus(32'h18, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, 32'h08, 1'b0, 1'b0);
      tick();
      checkOutput("mid_bvalid_pre", 64'(bvalid), 64'(1));
      checkOutput("mid_rvalid_pre", 64'(rvalid), 64'(1));
      resetn = 1'b0;
      #1;
      checkOutput("mid_bvalid", 64'(bvalid), 64'(0));
      checkOutput("mid_rvalid", 64'(rvalid), 64'(0));
      checkOutput("mid_readies", 64'({awready, wready, arready}), 64'(0));
      checkOutput("mid_rdata", 64'(rdata), 64'(0));
      checkOutput("mid_regs", 64'(|reg_out), 64'(0));
      checkOutput("mid_wr_pulse", 64'(wr_pulse), 64'(0));
      tick();
      resetn = 1'b1;
      tick();
      checkOutput("mid_readies_back", 64'({awready, wready, arready}), 64'(7));
      checkOutput("mid_regs_after", 64'(|reg_out), 64'(0));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
